// File: rtl/tff_step_gen_pkg.sv
// Shared encodings for the T0 step generator: debounce FSM states, mode values
// and a counter-width helper used by both the debouncer and the prescaler.
package tff_step_gen_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tff_step_gen_btn_debounce.sv
// Pushbutton synchroniser plus debounce FSM. Produces a registered debounced
// level and a combinational one-cycle press event on the accepting edge.
module btn_debounce
  import tff_step_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_evt,
  output logic [1:0] state_dbg
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  assign s         = sync_q[SYNC_STAGES-1];
  assign btn_level = level_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // The count includes the sample that caused entry into a WAIT state, so the
  // transition fires after DEBOUNCE_CYCLES consecutive stable samples.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = PRESSED;
          cnt_d     = '0;
          level_d   = 1'b1;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/tff_step_gen.sv
// Step-enable generator for the 2-bit T-flip-flop counter: debounced button
// pulses in manual mode, prescaled periodic pulses in auto mode.
module tff_step_gen
  import tff_step_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRESCALE        = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       mode,
  input  logic       run,
  output logic       t_out,
  output logic       btn_level,
  output logic [1:0] dbg_state
);

  localparam int            PW     = cnt_width(PRESCALE);
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PS_ONE = PW'(1);

  logic          press_evt;
  logic          mode_q;
  logic [PW-1:0] ps_q;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .press_evt(press_evt),
    .state_dbg(dbg_state)
  );

  // A mode change takes one quiet cycle: prescaler restarts and any press
  // event landing on that cycle is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_MANUAL;
      ps_q   <= '0;
      t_out  <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode != mode_q) begin
        ps_q  <= '0;
        t_out <= 1'b0;
      end else if (mode == MODE_AUTO) begin
        if (!run) begin
          ps_q  <= '0;
          t_out <= 1'b0;
        end else if (ps_q == PS_MAX) begin
          ps_q  <= '0;
          t_out <= 1'b1;
        end else begin
          ps_q  <= ps_q + PS_ONE;
          t_out <= 1'b0;
        end
      end else begin
        ps_q  <= '0;
        t_out <= press_evt;
      end
    end
  end

endmodule

// File: tb/tb_tff_step_gen.sv
// Directed bench for tff_step_gen at default parameters (2 sync stages,
// 16-cycle debounce, prescale 4): pulse timing, debounce, auto mode, gating.
module tb_tff_step_gen;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       mode;
  logic       run;
  logic       t_out;
  logic       btn_level;
  logic [1:0] dbg_state;

  int pass_cnt;
  int total_cnt;

  tff_step_gen #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16),
    .PRESCALE       (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_in   (btn_in),
    .mode     (mode),
    .run      (run),
    .t_out    (t_out),
    .btn_level(btn_level),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 1'b1;
    mode   = 1'b0;
    run    = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== 1'b0 || dbg_state !== 2'd0)
        $display("FAIL reset e=%0d t_out=%b btn_level=%b state=%0d exp 0/0/0",
                 e, t_out, btn_level, dbg_state);
      else pass_cnt++;
    end
    reset = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== (e == 18) || btn_level !== (e >= 18))
        $display("FAIL post_reset_press e=%0d t_out=%b exp=%b btn_level=%b exp=%b",
                 e, t_out, (e == 18), btn_level, (e >= 18));
      else pass_cnt++;
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== (e < 18))
        $display("FAIL post_reset_release e=%0d t_out=%b exp=0 btn_level=%b exp=%b",
                 e, t_out, btn_level, (e < 18));
      else pass_cnt++;
    end
  endtask

  task automatic test_clean_press();
    btn_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== (e == 18) || btn_level !== (e >= 18))
        $display("FAIL clean_press e=%0d t_out=%b exp=%b btn_level=%b exp=%b",
                 e, t_out, (e == 18), btn_level, (e >= 18));
      else pass_cnt++;
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== (e < 18))
        $display("FAIL clean_release e=%0d t_out=%b exp=0 btn_level=%b exp=%b",
                 e, t_out, btn_level, (e < 18));
      else pass_cnt++;
    end
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 55; e++) begin
      btn_in = (e <= 30) ? ((e % 6) != 0) : 1'b0;
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== 1'b0)
        $display("FAIL bounce e=%0d t_out=%b btn_level=%b exp 0/0", e, t_out, btn_level);
      else pass_cnt++;
    end
  endtask

  // A short low glitch while held must return to PRESSED without a new pulse.
  task automatic test_release_glitch();
    logic exp_lvl;
    btn_in = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      btn_in  = !(e >= 30 && e <= 34);
      exp_lvl = (e >= 18);
      step();
      total_cnt++;
      if (t_out !== (e == 18) || btn_level !== exp_lvl)
        $display("FAIL release_glitch e=%0d t_out=%b exp=%b btn_level=%b exp=%b",
                 e, t_out, (e == 18), btn_level, exp_lvl);
      else pass_cnt++;
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 20; e++) step();
    total_cnt++;
    if (btn_level !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL glitch_settle btn_level=%b state=%0d exp 0/0", btn_level, dbg_state);
    else pass_cnt++;
  endtask

  task automatic test_auto();
    logic exp_t;
    mode = 1'b1;
    run  = 1'b0;
    for (int e = 1; e <= 2; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0) $display("FAIL auto_arm e=%0d t_out=%b exp=0", e, t_out);
      else pass_cnt++;
    end
    run = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_t = ((e % 4) == 0);
      total_cnt++;
      if (t_out !== exp_t) $display("FAIL auto_run e=%0d t_out=%b exp=%b", e, t_out, exp_t);
      else pass_cnt++;
    end
    run = 1'b0;
    step();
    step();
    for (int e = 1; e <= 20; e++) begin
      run = !(e >= 14 && e <= 16);
      step();
      exp_t = (e == 4 || e == 8 || e == 12 || e == 20);
      total_cnt++;
      if (t_out !== exp_t) $display("FAIL auto_gap e=%0d t_out=%b exp=%b", e, t_out, exp_t);
      else pass_cnt++;
    end
    run = 1'b0;
    step();
  endtask

  task automatic test_mode_gating();
    mode   = 1'b1;
    run    = 1'b0;
    btn_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== (e >= 18))
        $display("FAIL mode_gate_press e=%0d t_out=%b exp=0 btn_level=%b exp=%b",
                 e, t_out, btn_level, (e >= 18));
      else pass_cnt++;
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== (e < 18))
        $display("FAIL mode_gate_release e=%0d t_out=%b exp=0 btn_level=%b exp=%b",
                 e, t_out, btn_level, (e < 18));
      else pass_cnt++;
    end
  endtask

  // Press accepted on the same edge mode falls 1->0: the pulse is dropped.
  task automatic test_mode_switch_drop();
    mode   = 1'b1;
    run    = 1'b0;
    btn_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 18) mode = 1'b0;
      step();
      total_cnt++;
      if (t_out !== 1'b0 || btn_level !== (e >= 18))
        $display("FAIL mode_switch_drop e=%0d t_out=%b exp=0 btn_level=%b exp=%b",
                 e, t_out, btn_level, (e >= 18));
      else pass_cnt++;
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 20; e++) step();
  endtask

  task automatic test_reset_mid_debounce();
    mode   = 1'b0;
    run    = 1'b0;
    btn_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      step();
      total_cnt++;
      if (t_out !== 1'b0) $display("FAIL mid_pre e=%0d t_out=%b exp=0", e, t_out);
      else pass_cnt++;
    end
    total_cnt++;
    if (dbg_state !== 2'd1) $display("FAIL mid_state state=%0d exp=1", dbg_state);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (t_out !== 1'b0 || btn_level !== 1'b0 || dbg_state !== 2'd0)
      $display("FAIL mid_reset t_out=%b btn_level=%b state=%0d exp 0/0/0",
               t_out, btn_level, dbg_state);
    else pass_cnt++;
    for (int e = 1; e <= 40; e++) begin
      step();
      total_cnt++;
      if (t_out !== (e == 18) || btn_level !== (e >= 18))
        $display("FAIL mid_after e=%0d t_out=%b exp=%b btn_level=%b exp=%b",
                 e, t_out, (e == 18), btn_level, (e >= 18));
      else pass_cnt++;
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 20; e++) step();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    btn_in    = 1'b0;
    mode      = 1'b0;
    run       = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_auto();
    test_mode_gating();
    test_mode_switch_drop();
    test_reset_mid_debounce();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
